// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode constants,
// FSM state encoding and the datapath select/ALU encodings also used by the
// datapath and ALU-control blocks.
package cpu_pkg;

  localparam int unsigned CPU_OPCODE_W = 6;
  localparam int unsigned CPU_STATE_W  = 4;

  localparam int unsigned OP_RTYPE = 0;
  localparam int unsigned OP_J     = 2;
  localparam int unsigned OP_JAL   = 3;
  localparam int unsigned OP_BEQ   = 4;
  localparam int unsigned OP_BNE   = 5;
  localparam int unsigned OP_ADDI  = 8;
  localparam int unsigned OP_ANDI  = 12;
  localparam int unsigned OP_ORI   = 13;
  localparam int unsigned OP_LW    = 35;
  localparam int unsigned OP_SW    = 43;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_FAULT    = 4'd13
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_LOGIC = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef enum logic [1:0] {
    RDST_RT = 2'b00,
    RDST_RD = 2'b01,
    RDST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } mem_to_reg_e;

  typedef struct packed {
    logic rtype;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic imm;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/cpu_opcode_class.sv
// Combinational opcode classifier feeding the DECODE-state transition.
// Ports:
//   opcode_i  instruction opcode field
//   class_o   one-hot class {rtype,load,store,branch,jump,imm,illegal}
module cpu_opcode_class
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W = CPU_OPCODE_W
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output op_class_t           class_o
);

  always_comb begin
    class_o = '0;
    case (opcode_i)
      OPCODE_W'(OP_RTYPE):                    class_o.rtype  = 1'b1;
      OPCODE_W'(OP_LW):                       class_o.load   = 1'b1;
      OPCODE_W'(OP_SW):                       class_o.store  = 1'b1;
      OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNE):   class_o.branch = 1'b1;
      OPCODE_W'(OP_J), OPCODE_W'(OP_JAL):     class_o.jump   = 1'b1;
      OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
      OPCODE_W'(OP_ORI):                      class_o.imm    = 1'b1;
      default:                                class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_control.sv
// Multicycle MIPS control unit. A Moore FSM steps each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects, ALU
// op, register-file and memory strobes. Memory states wait on mem_ready with a
// timeout; illegal opcodes and timeouts park the FSM in an absorbing FAULT.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   instr_opcode          IR[31:26], captured in DECODE only
//   mem_ready             memory completes access this cycle
//   pc_write, pc_write_cond, branch_ne, pc_source   PC update controls
//   iord, mem_read, mem_write, ir_write             memory/IR controls
//   reg_dst, mem_to_reg, reg_write                  register-file controls
//   alu_src_a, alu_src_b, alu_op                    ALU operand/op selects
//   instr_done            one-cycle retire pulse
//   fault                 sticky fault (illegal opcode or memory timeout)
//   state                 current FSM state (debug)
module cpu_multicycle_control
  import cpu_pkg::*;
#(
  parameter int unsigned OPCODE_W    = CPU_OPCODE_W,
  parameter int unsigned STATE_W     = CPU_STATE_W,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] instr_opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                instr_done,
  output logic                fault,
  output logic [STATE_W-1:0]  state
);

  // One bit minimum so the counter still exists when the timeout is disabled.
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  op_class_t           dec_class;
  logic                in_mem_state;
  logic                timeout;

  function automatic logic op_is(input logic [OPCODE_W-1:0] op, input int unsigned code);
    return op == OPCODE_W'(code);
  endfunction

  cpu_opcode_class #(
    .OPCODE_W(OPCODE_W)
  ) u_opcode_class (
    .opcode_i(instr_opcode),
    .class_o (dec_class)
  );

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Fires on the MEM_TIMEOUT-th consecutive stalled cycle, so FAULT is
  // entered on the following edge with the strobes dropped.
  assign timeout = (MEM_TIMEOUT != 0) && in_mem_state && !mem_ready &&
                   (wait_q == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = instr_opcode;
        if (dec_class.rtype)                        state_d = S_R_EXEC;
        else if (dec_class.load || dec_class.store) state_d = S_MEM_ADDR;
        else if (dec_class.branch)                  state_d = S_BRANCH;
        else if (dec_class.jump)                    state_d = S_JUMP;
        else if (dec_class.imm)                     state_d = S_I_EXEC;
        else                                        state_d = S_FAULT;
      end
      S_MEM_ADDR: state_d = op_is(op_q, OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase

    // Default of zero clears the counter on entry to each memory state and
    // on any completing cycle; it only advances while stalled in place.
    if (timeout) begin
      state_d = S_FAULT;
    end else if ((MEM_TIMEOUT != 0) && in_mem_state && !mem_ready) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_dst    = RDST_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = op_is(op_q, OP_ADDI) ? ALU_ADD : ALU_LOGIC;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = op_is(op_q, OP_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        if (op_is(op_q, OP_JAL)) begin
          reg_write  = 1'b1;
          reg_dst    = RDST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_multicycle_control.sv
module tb_cpu_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic       bne;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] rdst;
    logic [1:0] m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       done;
    logic       flt;
  } obs_t;

  typedef struct {
    obs_t  v;
    string nm;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] instr_opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_write, alu_src_a, instr_done, fault;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state;
  obs_t       obs;

  int unsigned checks = 0;
  int unsigned errors = 0;
  sb_t         sb[$];

  localparam logic [5:0] X = 6'd63;

  cpu_multicycle_control #(
    .OPCODE_W   (6),
    .STATE_W    (4),
    .MEM_TIMEOUT(15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_opcode (instr_opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_ne    (branch_ne),
    .pc_source    (pc_source),
    .iord         (iord),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .instr_done   (instr_done),
    .fault        (fault),
    .state        (state)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read,
                mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                alu_src_b, alu_op, instr_done, fault};

  // Hand-written expected control word for each state.
  function automatic obs_t e_reset();
    obs_t e = '0;
    return e;
  endfunction
  function automatic obs_t e_fetch(input logic rdy);
    obs_t e = '0;
    e.st = 4'd1; e.mr = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy;
    return e;
  endfunction
  function automatic obs_t e_decode();
    obs_t e = '0;
    e.st = 4'd2; e.asb = 2'b11;
    return e;
  endfunction
  function automatic obs_t e_memaddr();
    obs_t e = '0;
    e.st = 4'd3; e.asa = 1'b1; e.asb = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_memrd();
    obs_t e = '0;
    e.st = 4'd4; e.mr = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_memwb();
    obs_t e = '0;
    e.st = 4'd5; e.m2r = 2'b01; e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_memwr(input logic rdy);
    obs_t e = '0;
    e.st = 4'd6; e.mw = 1'b1; e.iord = 1'b1; e.done = rdy;
    return e;
  endfunction
  function automatic obs_t e_rexec();
    obs_t e = '0;
    e.st = 4'd7; e.asa = 1'b1; e.aop = 2'b10;
    return e;
  endfunction
  function automatic obs_t e_rwb();
    obs_t e = '0;
    e.st = 4'd8; e.rdst = 2'b01; e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_iexec(input logic logic_op);
    obs_t e = '0;
    e.st = 4'd9; e.asa = 1'b1; e.asb = 2'b10; e.aop = logic_op ? 2'b11 : 2'b00;
    return e;
  endfunction
  function automatic obs_t e_iwb();
    obs_t e = '0;
    e.st = 4'd10; e.rw = 1'b1; e.done = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_branch(input logic ne);
    obs_t e = '0;
    e.st = 4'd11; e.asa = 1'b1; e.aop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01;
    e.bne = ne; e.done = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_jump(input logic link);
    obs_t e = '0;
    e.st = 4'd12; e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
    if (link) begin
      e.rw = 1'b1; e.rdst = 2'b10; e.m2r = 2'b10;
    end
    return e;
  endfunction
  function automatic obs_t e_fault();
    obs_t e = '0;
    e.st = 4'd13; e.flt = 1'b1;
    return e;
  endfunction

  // One cycle of stimulus: drive inputs just after the edge, queue the
  // expected outputs for this cycle.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy,
                     input obs_t e, input string nm);
    sb_t item;
    @(posedge clk);
    #1;
    rst_n        = rst;
    instr_opcode = op;
    mem_ready    = rdy;
    item.v  = e;
    item.nm = nm;
    sb.push_back(item);
  endtask

  // Monitor: compare the DUT each cycle away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t item;
      item = sb.pop_front();
      checks++;
      if (obs !== item.v) begin
        errors++;
        $display("FAIL %s: got state=%0d ctl=%06h, expected state=%0d ctl=%06h",
                 item.nm, obs.st, obs[20:0], item.v.st, item.v[20:0]);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    instr_opcode = 6'd0;
    mem_ready    = 1'b0;

    // reset
    cyc(0, X, 1, e_reset(), "reset_hold0");
    cyc(0, X, 1, e_reset(), "reset_hold1");
    cyc(1, X, 1, e_reset(), "reset_release");

    // add: 4 cycles, retire only in R_WB
    cyc(1, 6'd35, 1, e_fetch(1), "add_fetch");
    cyc(1, 6'd0,  0, e_decode(), "add_decode");
    cyc(1, X,     1, e_rexec(),  "add_rexec");
    cyc(1, X,     0, e_rwb(),    "add_rwb");

    // lw with 3 wait states: 8 cycles
    cyc(1, X,     1, e_fetch(1),  "lw_fetch");
    cyc(1, 6'd35, 1, e_decode(),  "lw_decode");
    cyc(1, X,     0, e_memaddr(), "lw_addr");
    cyc(1, X,     0, e_memrd(),   "lw_rd_wait1");
    cyc(1, X,     0, e_memrd(),   "lw_rd_wait2");
    cyc(1, X,     0, e_memrd(),   "lw_rd_wait3");
    cyc(1, X,     1, e_memrd(),   "lw_rd_done");
    cyc(1, X,     0, e_memwb(),   "lw_wb");

    // sw, zero wait
    cyc(1, X,     1, e_fetch(1),  "sw_fetch");
    cyc(1, 6'd43, 1, e_decode(),  "sw_decode");
    cyc(1, X,     1, e_memaddr(), "sw_addr");
    cyc(1, X,     1, e_memwr(1),  "sw_wr");

    // addi after fetch wait states
    cyc(1, X,    0, e_fetch(0), "addi_fetch_wait1");
    cyc(1, X,    0, e_fetch(0), "addi_fetch_wait2");
    cyc(1, X,    1, e_fetch(1), "addi_fetch");
    cyc(1, 6'd8, 1, e_decode(), "addi_decode");
    cyc(1, X,    1, e_iexec(0), "addi_iexec");
    cyc(1, X,    1, e_iwb(),    "addi_iwb");

    // ori
    cyc(1, X,     1, e_fetch(1), "ori_fetch");
    cyc(1, 6'd13, 1, e_decode(), "ori_decode");
    cyc(1, X,     1, e_iexec(1), "ori_iexec");
    cyc(1, X,     1, e_iwb(),    "ori_iwb");

    // beq / bne
    cyc(1, X,    1, e_fetch(1),  "beq_fetch");
    cyc(1, 6'd4, 1, e_decode(),  "beq_decode");
    cyc(1, 6'd5, 1, e_branch(0), "beq_branch");
    cyc(1, X,    1, e_fetch(1),  "bne_fetch");
    cyc(1, 6'd5, 1, e_decode(),  "bne_decode");
    cyc(1, 6'd4, 1, e_branch(1), "bne_branch");

    // j / jal
    cyc(1, X,    1, e_fetch(1), "j_fetch");
    cyc(1, 6'd2, 1, e_decode(), "j_decode");
    cyc(1, 6'd3, 1, e_jump(0),  "j_jump");
    cyc(1, X,    1, e_fetch(1), "jal_fetch");
    cyc(1, 6'd3, 1, e_decode(), "jal_decode");
    cyc(1, 6'd2, 1, e_jump(1),  "jal_jump");

    // 14 stalled fetch cycles is one short of the timeout
    for (int i = 0; i < 14; i++) cyc(1, X, 0, e_fetch(0), "fetch_stall14");
    cyc(1, X,    1, e_fetch(1), "fetch_stall14_done");
    cyc(1, 6'd0, 1, e_decode(), "stall14_decode");
    cyc(1, X,    1, e_rexec(),  "stall14_rexec");
    cyc(1, X,    1, e_rwb(),    "stall14_rwb");

    // illegal opcode -> sticky fault
    cyc(1, X,     1, e_fetch(1), "ill_fetch");
    cyc(1, 6'd63, 1, e_decode(), "ill_decode");
    cyc(1, 6'd0,  1, e_fault(),  "ill_fault0");
    cyc(1, 6'd0,  0, e_fault(),  "ill_fault1");
    cyc(1, 6'd35, 1, e_fault(),  "ill_fault2");
    cyc(0, X,     1, e_reset(),  "ill_reset");
    cyc(1, X,     1, e_reset(),  "ill_release");

    // 15 stalled fetch cycles -> fault
    for (int i = 0; i < 15; i++) cyc(1, X, 0, e_fetch(0), "fetch_stall15");
    cyc(1, X, 0, e_fault(), "timeout_fault0");
    cyc(1, X, 1, e_fault(), "timeout_fault1");
    cyc(0, X, 0, e_reset(), "to_reset");
    cyc(1, X, 0, e_reset(), "to_release");

    // reset mid-wait in MEM_WR, then clean restart
    cyc(1, X,     1, e_fetch(1),  "swr_fetch");
    cyc(1, 6'd43, 1, e_decode(),  "swr_decode");
    cyc(1, X,     0, e_memaddr(), "swr_addr");
    cyc(1, X,     0, e_memwr(0),  "swr_wait1");
    cyc(1, X,     0, e_memwr(0),  "swr_wait2");
    cyc(0, X,     1, e_reset(),   "swr_reset_midwait");
    cyc(1, X,     1, e_reset(),   "swr_release");
    cyc(1, X,     1, e_fetch(1),  "swr_refetch");
    cyc(1, 6'd0,  1, e_decode(),  "swr_redecode");
    cyc(1, X,     1, e_rexec(),   "swr_rexec");

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
